// File: rtl/nway_cache_if.sv
// nway_cache_if: CPU access port and SDRAM burst-fill port of the n-way read cache.
interface nway_cache_if #(parameter int ADDR_BITS = 26);
    logic                 ready;
    logic [ADDR_BITS-1:0] cpu_addr;
    logic                 cpu_req;
    logic                 cpu_rw_n;
    logic                 cpu_rwl_n;
    logic                 cpu_rwu_n;
    logic [15:0]          data_from_cpu;
    logic [15:0]          data_to_cpu;
    logic                 cpu_ack;
    logic                 cpu_cachevalid;
    logic                 flush;
    logic                 sdram_req;
    logic                 sdram_fill;
    logic [15:0]          data_from_sdram;
    modport slave (
        input  cpu_addr, cpu_req, cpu_rw_n, cpu_rwl_n, cpu_rwu_n, data_from_cpu, flush,
               sdram_fill, data_from_sdram,
        output ready, data_to_cpu, cpu_ack, cpu_cachevalid, sdram_req
    );
    modport master (
        output cpu_addr, cpu_req, cpu_rw_n, cpu_rwl_n, cpu_rwu_n, data_from_cpu, flush,
               sdram_fill, data_from_sdram,
        input  ready, data_to_cpu, cpu_ack, cpu_cachevalid, sdram_req
    );
endinterface

// File: rtl/nway_cache.sv
// nway_cache: N-way set-associative write-through read cache with critical-word-first
// burst fill, lowest-invalid-then-round-robin replacement and a full-cache flush.
module nway_cache #(
    parameter int ADDR_BITS  = 26,
    parameter int WAYS       = 2,
    parameter int SETS_LOG2  = 8,
    parameter int BURST_LOG2 = 2
) (
    input logic         clk,
    input logic         reset_n,
    nway_cache_if.slave io_bus
);
    localparam int WORDS = 1 << BURST_LOG2;
    localparam int SETS  = 1 << SETS_LOG2;
    localparam int AW    = SETS_LOG2 + BURST_LOG2;
    localparam int TW    = ADDR_BITS - AW - 1;
    localparam int WL    = $clog2(WAYS);

    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, MISS, FILL, ACKWAIT} state_t;

    state_t                r_state;
    logic [AW-1:0]         r_cnt;
    logic [ADDR_BITS-1:1]  r_addr;
    logic                  r_rw;
    logic [1:0]            r_be;
    logic [15:0]           r_wd;
    logic [WL-1:0]         r_fw;
    logic [BURST_LOG2-1:0] r_off;
    logic [15:0]           r_sd;
    logic [15:0]           r_dout;
    logic                  r_ack;
    logic                  r_sreq;
    logic                  r_ready;
    logic                  r_flush;

    // Storage arrays carry no reset; the INIT sweep establishes their valid state.
    logic [TW-1:0]         r_tag [WAYS][SETS];
    logic [17:0]           r_mem [WAYS][SETS*WORDS];
    logic                  r_lv  [WAYS][SETS];
    logic [WL-1:0]         r_vp  [SETS];
    logic [17:0]           r_rd  [WAYS];

    logic [SETS_LOG2-1:0]  w_idx;
    logic [BURST_LOG2-1:0] w_word;
    logic [TW-1:0]         w_tag;
    logic [WAYS-1:0]       w_match;
    logic [WAYS-1:0]       w_we;
    logic [17:0]           w_wdata [WAYS];
    logic [AW-1:0]         w_waddr;
    logic                  w_hit;
    logic [15:0]           w_hdata;
    logic [WL-1:0]         w_fw;
    logic                  w_use_vp;
    logic                  w_alloc;

    assign w_idx   = r_addr[AW:BURST_LOG2+1];
    assign w_word  = r_addr[BURST_LOG2:1];
    assign w_tag   = r_addr[ADDR_BITS-1:AW+1];
    assign w_alloc = r_state == LOOKUP && r_rw && !w_hit;
    assign w_waddr = r_state == INIT ? r_cnt : r_state == FILL ? {w_idx, r_off} : r_addr[AW:1];

    assign io_bus.ready          = r_ready;
    assign io_bus.data_to_cpu    = r_dout;
    assign io_bus.cpu_ack        = r_ack;
    assign io_bus.cpu_cachevalid = r_state == LOOKUP && r_rw && w_hit;
    assign io_bus.sdram_req      = r_sreq;

    // Downward loops leave the lowest-numbered qualifying way selected.
    always_comb begin
        w_hit    = 1'b0;
        w_hdata  = '0;
        w_match  = '0;
        w_we     = '0;
        w_fw     = r_vp[w_idx];
        w_use_vp = 1'b1;
        for (int k = WAYS - 1; k >= 0; k--) begin
            w_match[k] = r_lv[k][w_idx] && r_tag[k][w_idx] == w_tag;
            w_we[k]    = r_state == INIT || (r_state == LOOKUP && !r_rw && w_match[k]) ||
                         (r_state == FILL && r_fw == WL'(k));
            w_wdata[k] = r_state == INIT ? 18'd0 : r_state == FILL ? {2'b11, r_sd} :
                         {r_rd[k][17] | r_be[1], r_rd[k][16] | r_be[0],
                          r_be[1] ? r_wd[15:8] : r_rd[k][15:8], r_be[0] ? r_wd[7:0] : r_rd[k][7:0]};
            if (w_match[k] && &r_rd[k][17:16]) begin
                w_hit   = 1'b1;
                w_hdata = r_rd[k][15:0];
            end
            if (!r_lv[k][w_idx]) begin
                w_fw     = WL'(k);
                w_use_vp = 1'b0;
            end
        end
        for (int k = WAYS - 1; k >= 0; k--) begin
            if (w_match[k] && !(&r_rd[k][17:16])) begin
                w_fw     = WL'(k);
                w_use_vp = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < WAYS; k++) begin
            r_rd[k] <= r_mem[k][io_bus.cpu_addr[AW:1]];
            if (w_we[k]) r_mem[k][w_waddr] <= w_wdata[k];
            if (r_state == INIT) r_lv[k][r_cnt[AW-1:BURST_LOG2]] <= 1'b0;
        end
        if (r_state == INIT) r_vp[r_cnt[AW-1:BURST_LOG2]] <= '0;
        if (w_alloc) begin
            r_tag[w_fw][w_idx] <= w_tag;
            r_lv[w_fw][w_idx]  <= 1'b1;
            if (w_use_vp) r_vp[w_idx] <= r_vp[w_idx] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= INIT;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_be    <= '0;
            r_wd    <= '0;
            r_fw    <= '0;
            r_off   <= '0;
            r_sd    <= '0;
            r_dout  <= '0;
            r_ack   <= 1'b0;
            r_sreq  <= 1'b0;
            r_ready <= 1'b0;
            r_flush <= 1'b0;
        end else begin
            r_sd <= io_bus.data_from_sdram;
            if (io_bus.flush) r_flush <= 1'b1;
            case (r_state)
                INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (&r_cnt) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (r_flush || io_bus.flush) begin
                        r_state <= INIT;
                        r_ready <= 1'b0;
                        r_flush <= 1'b0;
                        r_cnt   <= '0;
                    end else if (io_bus.cpu_req) begin
                        r_addr  <= io_bus.cpu_addr[ADDR_BITS-1:1];
                        r_rw    <= io_bus.cpu_rw_n;
                        r_be    <= {~io_bus.cpu_rwu_n, ~io_bus.cpu_rwl_n};
                        r_wd    <= io_bus.data_from_cpu;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    r_ack   <= !r_rw || w_hit;
                    r_sreq  <= w_alloc;
                    r_fw    <= w_fw;
                    r_state <= w_alloc ? MISS : ACKWAIT;
                    if (r_rw && w_hit) r_dout <= w_hdata;
                end
                MISS: begin
                    if (io_bus.sdram_fill) begin
                        r_sreq  <= 1'b0;
                        r_off   <= w_word;
                        r_cnt   <= '0;
                        r_state <= FILL;
                    end
                end
                // Burst words are registered once, so the critical word lands one cycle after sdram_fill.
                FILL: begin
                    r_off <= r_off + 1'b1;
                    r_cnt <= r_cnt + 1'b1;
                    r_ack <= r_cnt == '0;
                    if (r_cnt == '0) r_dout <= r_sd;
                    if (r_cnt == AW'(WORDS - 1)) r_state <= IDLE;
                end
                ACKWAIT: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_nway_cache.sv
// tb_nway_cache: directed and random accesses on a 4-way nway_cache, checked against a
// line-level cache model with its own SDRAM image.
module tb_nway_cache;
    localparam int AB = 26;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    nway_cache_if #(.ADDR_BITS(AB)) bus ();
    nway_cache #(.ADDR_BITS(AB), .WAYS(NW), .SETS_LOG2(8), .BURST_LOG2(2)) dut (
        .clk(clk), .reset_n(reset_n), .io_bus(bus)
    );

    always #5 clk = ~clk;

    bit          m_lv  [256][NW];
    logic [14:0] m_tag [256][NW];
    logic [15:0] m_dat [256][NW][4];
    int          m_vp  [256];
    logic [15:0] mem   [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sd_word(input int wa);
        return mem.exists(wa) ? mem[wa] : 16'(wa * 40503 + 4660);
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [1:0] be, input logic [15:0] d);
        return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 256; s++) begin
            m_vp[s] = 0;
            for (int w = 0; w < NW; w++) m_lv[s][w] = 1'b0;
        end
    endfunction

    function automatic void model_read(input logic [25:0] a, output bit hit, output logic [15:0] d);
        int s, wd, fw, base;
        logic [14:0] t;
        s = int'(a[10:3]); t = a[25:11]; wd = int'(a[2:1]); fw = -1; base = int'(a[25:3]) * 4;
        hit = 1'b0; d = '0;
        for (int w = 0; w < NW; w++)
            if (!hit && m_lv[s][w] && m_tag[s][w] == t) begin hit = 1'b1; d = m_dat[s][w][wd]; end
        if (hit) return;
        for (int w = NW - 1; w >= 0; w--) if (!m_lv[s][w]) fw = w;
        if (fw < 0) begin fw = m_vp[s]; m_vp[s] = (m_vp[s] + 1) % NW; end
        m_lv[s][fw] = 1'b1; m_tag[s][fw] = t;
        for (int k = 0; k < 4; k++) m_dat[s][fw][k] = sd_word(base + k);
        d = m_dat[s][fw][wd];
    endfunction

    function automatic void model_write(input logic [25:0] a, input logic [1:0] be, input logic [15:0] d);
        int s, wd, wa;
        s = int'(a[10:3]); wd = int'(a[2:1]); wa = int'(a[25:1]);
        mem[wa] = merge(sd_word(wa), be, d);
        for (int w = 0; w < NW; w++)
            if (m_lv[s][w] && m_tag[s][w] == a[25:11]) m_dat[s][w][wd] = merge(m_dat[s][w][wd], be, d);
    endfunction

    // mode 0: plain access; 1: flush pulsed during the fill; 2: reset asserted while awaiting the burst
    task automatic tx(input logic [25:0] a, input bit rw_n, input logic [1:0] be, input logic [15:0] wdat, input int mode);
        bit hit;
        logic [15:0] exp;
        int base, crit, dly;
        if (rw_n) model_read(a, hit, exp);
        else begin model_write(a, be, wdat); hit = 1'b0; exp = '0; end
        bus.cpu_addr = a; bus.cpu_rw_n = rw_n; bus.cpu_rwu_n = ~be[1]; bus.cpu_rwl_n = ~be[0];
        bus.data_from_cpu = wdat; bus.cpu_req = 1'b1;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        chk("cachevalid", bus.cpu_cachevalid, rw_n && hit);
        if (!rw_n || hit) begin
            @(posedge clk); #1;
            chk("ack", bus.cpu_ack, 1);
            if (rw_n) chk("hit_data", bus.data_to_cpu, exp);
            @(posedge clk); #1;
            chk("ack_pulse", bus.cpu_ack, 0);
        end else begin
            @(posedge clk); #1;
            chk("sdram_req", bus.sdram_req, 1);
            if (mode == 2) begin
                reset_n = 1'b0; #1;
                chk("rst_sdram_req", bus.sdram_req, 0);
                chk("rst_ack", bus.cpu_ack, 0);
                return;
            end
            dly = $urandom_range(0, 3);
            repeat (dly) begin @(posedge clk); #1; end
            chk("req_held", bus.sdram_req, 1);
            base = int'(a[25:3]) * 4; crit = int'(a[2:1]);
            for (int k = 0; k < 4; k++) begin
                bus.sdram_fill = k == 0;
                bus.data_from_sdram = sd_word(base + (crit + k) % 4);
                bus.flush = mode == 1 && k == 1;
                @(posedge clk); #1;
                if (k == 0) chk("req_drop", bus.sdram_req, 0);
                if (k == 1) begin chk("miss_ack", bus.cpu_ack, 1); chk("miss_data", bus.data_to_cpu, exp); end
                if (k == 2) chk("miss_ack_pulse", bus.cpu_ack, 0);
            end
            bus.sdram_fill = 1'b0; bus.flush = 1'b0;
            @(posedge clk); #1;
            if (mode == 1) begin @(posedge clk); #1; chk("flush_ready_lo", bus.ready, 0); end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 1200 && !bus.ready; i++) begin @(posedge clk); #1; end
        chk("ready_up", bus.ready, 1);
    endtask

    initial begin
        bit noisy;
        logic [25:0] a;
        bus.cpu_addr = '0; bus.cpu_req = 1'b0; bus.cpu_rw_n = 1'b1; bus.cpu_rwl_n = 1'b1;
        bus.cpu_rwu_n = 1'b1; bus.data_from_cpu = '0; bus.flush = 1'b0; bus.sdram_fill = 1'b0;
        bus.data_from_sdram = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.ready, 0);
        chk("rst_ack", bus.cpu_ack, 0);
        chk("rst_cachevalid", bus.cpu_cachevalid, 0);
        chk("rst_sdram_req", bus.sdram_req, 0);
        chk("rst_data", bus.data_to_cpu, 0);
        reset_n = 1'b1;
        noisy = 1'b0;
        repeat (1023) begin
            @(posedge clk); #1;
            if (bus.ready || bus.cpu_ack || bus.cpu_cachevalid || bus.sdram_req || bus.data_to_cpu != 0) noisy = 1'b1;
        end
        chk("sweep_quiet", noisy, 0);
        chk("ready_lo_1023", bus.ready, 0);
        @(posedge clk); #1;
        chk("ready_hi_1024", bus.ready, 1);

        tx(26'h000106, 1, 2'b00, 16'h0, 0);
        tx(26'h000100, 1, 2'b00, 16'h0, 0);
        for (int t = 1; t <= 5; t++) tx(26'((t << 11) | (5 << 3)), 1, 2'b00, 16'h0, 0);
        tx(26'((2 << 11) | (5 << 3)), 1, 2'b00, 16'h0, 0);
        tx(26'((1 << 11) | (5 << 3)), 1, 2'b00, 16'h0, 0);
        tx(26'h000104, 0, 2'b10, 16'hAB00, 0);
        tx(26'h000104, 1, 2'b00, 16'h0, 0);
        tx(26'h1230040, 0, 2'b01, 16'h00CD, 0);
        tx(26'h1230040, 1, 2'b00, 16'h0, 0);

        repeat (200) begin
            a = 26'(($urandom_range(0, 5) << 11) | ($urandom_range(0, 3) << 3) | $urandom_range(0, 7));
            if ($urandom_range(0, 9) < 7) tx(a, 1, 2'b00, 16'h0, 0);
            else tx(a, 0, 2'($urandom_range(0, 3)), 16'($urandom), 0);
        end

        tx(26'((7 << 11) | (9 << 3)), 1, 2'b00, 16'h0, 1);
        wait_ready();
        model_clear();
        tx(26'h000106, 1, 2'b00, 16'h0, 0);
        tx(26'((2 << 11) | (5 << 3)), 1, 2'b00, 16'h0, 0);

        tx(26'((8 << 11) | (9 << 3) | 2), 1, 2'b00, 16'h0, 2);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_ready();
        model_clear();
        tx(26'((8 << 11) | (9 << 3) | 2), 1, 2'b00, 16'h0, 0);
        tx(26'((8 << 11) | (9 << 3) | 2), 1, 2'b00, 16'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nway_cache.md
# nway_cache

Parametrised N-way set-associative, write-through read cache between a 16-bit CPU port and the SDRAM controller's burst-fill port. It generalises the fixed two-way, 64 MiB design to configurable way count, set count, burst length and address width. It fills the first invalid way before evicting, uses a per-set round-robin victim, and adds a flush input. The CPU sees hits in two cycles; misses issue one SDRAM burst, returned critical-word-first.

## Interface
- ADDR_BITS, 26, CPU byte-address width
- WAYS, 2, associativity; 2, 4 or 8
- SETS_LOG2, 8, log2 sets per way
- BURST_LOG2, 2, log2 16-bit words per line (= SDRAM burst length)

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ready  out  1  high once invalidation sweep is complete
- cpu_addr  in  ADDR_BITS  byte address; bit 0 ignored
- cpu_req  in  1  access request, level
- cpu_rw_n  in  1  1 = read, 0 = write
- cpu_rwl_n, cpu_rwu_n  in  1 each  active-low lower/upper byte enables (writes)
- data_from_cpu  in  16  write data
- data_to_cpu  out  16  read data, valid while cpu_ack high
- cpu_ack  out  1  one-cycle completion pulse
- cpu_cachevalid  out  1  read hit indicator, LOOKUP cycle only
- flush  in  1  invalidate entire cache, pulse
- sdram_req  out  1  line-fill request
- sdram_fill  in  1  first burst word present on data_from_sdram
- data_from_sdram  in  16  burst data

## Operation
- Address fields:
  - word = cpu_addr[BURST_LOG2:1]
  - index = next SETS_LOG2 bits
  - tag = cpu_addr[ADDR_BITS-1:BURST_LOG2+SETS_LOG2+1]
- Storage per way:
  - Tag RAM (one entry per set).
  - Data RAM (one 18-bit entry per word: 2 byte-valid bits + 16 data bits). Synchronous read, 1-cycle latency.
  - Per-set victim pointer, log2(WAYS) bits.
- States: INIT, IDLE, LOOKUP, MISS, FILL, ACKWAIT.
- INIT:
  - Clears every byte-valid bit and victim pointer, one word index per cycle, all ways in parallel: 2^(SETS_LOG2+BURST_LOG2) cycles.
  - ready=0 throughout. Goes to IDLE, where ready=1.
- IDLE:
  - Pending flush goes to INIT.
  - Else cpu_req=1: latch address, rw, byte enables and data, then go to LOOKUP.
- LOOKUP, read:
  - Hit = tag match in a way with both byte-valid bits set. If several ways hit, the lowest-numbered way wins.
  - Hit: cpu_cachevalid=1, data registered, cpu_ack next cycle, go to ACKWAIT.
  - Miss: go to MISS. Fill way is chosen in this order:
    - a tag-matching way holding stale bytes;
    - else the lowest way with all words of the line invalid;
    - else the victim pointer, which then increments mod WAYS.
  - The fill way's tag is written in this cycle.
- LOOKUP, write:
  - Every tag-matching way updates the enabled bytes and sets their valid bits. Non-enabled bytes keep their contents and valid bits.
  - No allocation on write miss. SDRAM write is handled outside this block.
  - cpu_ack next cycle, go to ACKWAIT.
- MISS: sdram_req=1 until the cycle sdram_fill=1.
  - That word is the critical word (offset = latched word). It is written with valid=11 and loaded into data_to_cpu. Go to FILL.
- FILL:
  - The remaining 2^BURST_LOG2−1 words arrive on consecutive cycles, independent of sdram_fill.
  - Write offset increments modulo 2^BURST_LOG2 (wraps past the line end).
  - cpu_ack pulses in the first FILL cycle.
  - After the last word goes to IDLE; a flush seen during the fill is taken then.
- ACKWAIT: one cycle, ignores cpu_req, then IDLE.
- flush in any state other than IDLE is latched and serviced on the next IDLE.
- Async reset in any state: registers cleared, state INIT; an in-flight fill is abandoned.

## Timing
- Reset values:
  - ready=0, cpu_ack=0, cpu_cachevalid=0, sdram_req=0, data_to_cpu=0.
  - Flush latch cleared, state=INIT.
- cpu_req sampled only in IDLE. It must be deasserted no later than the cycle after cpu_ack, otherwise a new access starts.
- Read hit or write: req seen at edge E0, LOOKUP during E0–E1, cpu_ack high E1–E2. Latency 2 cycles; next request accepted at E3.
- Read miss:
  - sdram_req rises at E1.
  - First word at sdram_fill edge F: data_to_cpu valid and cpu_ack high F+1 to F+2.
  - ready to accept at F+2^BURST_LOG2+1.
- sdram_req is never reasserted before the current burst completes.

## Test plan
- Reset, then reset_n=1: ready stays 0 for 1024 cycles (SETS_LOG2=8, BURST_LOG2=2), then 1; all outputs 0 during the sweep.
- Read miss at 0x000106 (word 3): sdram_req rises; burst D3,D0,D1,D2 -> data_to_cpu=D3 with ack at F+1. Reread of 0x000100 hits: ack 2 cycles after req, cpu_cachevalid=1, data=D0.
- WAYS=4: fill five lines with the same index and distinct tags. Ways 0–3 fill first (lowest invalid), fifth goes to way 0; rereading the first tag misses, the second hits.
- Write upper byte only (rwu_n=0, rwl_n=1) 0xAB00 to a cached word: read returns {AB, old low}. Write lower byte only to an uncached address: no fill, next read misses.
- Flush asserted during FILL: burst completes, then ready=0 for the sweep. Every prior line then misses.
- reset_n low mid-burst: sdram_req=0 and cpu_ack=0 immediately. After the sweep, a read of that line misses.
